// File: rtl/branch_resolve_pkg.sv
// Shared types for EX-stage branch resolution.
// Branch kinds, FSM states and 64-bit address/data types.
package CorePack;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_COND,
    BR_JAL,
    BR_JALR
  } br_type_enum;

  typedef enum logic {
    IDLE,
    REDIR
  } br_state_e;

endpackage

// File: rtl/branch_resolve_br_target.sv
// Branch target adder and alignment check.
// Purely combinational; JALR clears bit 0 of its sum.
module br_target
  import CorePack::*;
(
  input  br_type_enum br_type,
  input  addr_t       pc,
  input  data_t       imm,
  input  data_t       rs1,
  output addr_t       target,
  output logic        misaligned
);

  addr_t sum_pc;
  addr_t sum_rs;

  assign sum_pc = pc + imm;
  assign sum_rs = rs1 + imm;

  always_comb begin
    target = sum_pc;
    unique case (1'b1)
      (br_type == BR_JALR): target = {sum_rs[63:1], 1'b0};
      default:              target = sum_pc;
    endcase
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution with redirect handshake.
// Predict-not-taken: any taken transfer redirects fetch.
module branch_resolve
  import CorePack::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid,
  input  br_type_enum      ex_br_type,
  input  addr_t            ex_pc,
  input  data_t            ex_imm,
  input  data_t            ex_rs1,
  input  logic             cmp_res,
  input  logic             trap_flush,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output addr_t            redirect_pc,
  output logic             flush_front,
  output logic             stall_ex,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  br_state_e        state_q, state_d;
  logic             rv_q, rv_d;
  addr_t            rpc_q, rpc_d;
  logic             flush_q, flush_d;
  logic             stall_q, stall_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

  addr_t tgt;
  logic  tgt_mis;
  logic  is_br;
  logic  taken;

  br_target u_tgt (
    .br_type    (ex_br_type),
    .pc         (ex_pc),
    .imm        (ex_imm),
    .rs1        (ex_rs1),
    .target     (tgt),
    .misaligned (tgt_mis)
  );

  assign is_br = ex_valid && (ex_br_type != BR_NONE);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (ex_br_type == BR_JAL):  taken = ex_valid;
      (ex_br_type == BR_JALR): taken = ex_valid;
      (ex_br_type == BR_COND): taken = ex_valid && cmp_res;
      default:                 taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rv_d     = rv_q;
    rpc_d    = rpc_q;
    flush_d  = 1'b0;
    stall_d  = stall_q;
    mis_d    = 1'b0;
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!trap_flush) begin
          if (is_br) br_cnt_d = br_cnt_q + CNT_W'(1);
          if (taken && tgt_mis) begin
            mis_d = 1'b1;
          end else if (taken) begin
            state_d  = REDIR;
            rv_d     = 1'b1;
            rpc_d    = tgt;
            flush_d  = 1'b1;
            stall_d  = 1'b1;
            tk_cnt_d = tk_cnt_q + CNT_W'(1);
          end
        end
      end
      REDIR: begin
        // a trap wins over a completing handshake
        if (trap_flush || redirect_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
          stall_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rv_d    = 1'b0;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rv_q     <= 1'b0;
      rpc_q    <= '0;
      flush_q  <= 1'b0;
      stall_q  <= 1'b0;
      mis_q    <= 1'b0;
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rv_q     <= rv_d;
      rpc_q    <= rpc_d;
      flush_q  <= flush_d;
      stall_q  <= stall_d;
      mis_q    <= mis_d;
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign flush_front    = flush_q;
  assign stall_ex       = stall_q;
  assign misalign_exc   = mis_q;
  assign br_cnt         = br_cnt_q;
  assign taken_cnt      = tk_cnt_q;

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 32, the width of the statistics counters.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-005 Port: ex_valid  in  1  the EX stage holds a valid instruction this cycle.
REQ-006 Port: ex_br_type  in  br_type_enum  one of BR_NONE, BR_COND, BR_JAL, BR_JALR.
REQ-007 Port: ex_pc  in  addr_t (64)  PC of the EX instruction.
REQ-008 Port: ex_imm  in  data_t (64)  sign-extended immediate.
REQ-009 Port: ex_rs1  in  data_t (64)  rs1 operand value.
REQ-010 Port: cmp_res  in  1  branch-comparator result for the EX instruction.
REQ-011 Port: trap_flush  in  1  kill request from a later stage; has priority over everything else.
REQ-012 Port: redirect_ready  in  1  fetch accepts a redirect this cycle.
REQ-013 Port: redirect_valid  out  1  a redirect request is pending.
REQ-014 Port: redirect_pc  out  addr_t (64)  the redirect target.
REQ-015 Port: flush_front  out  1  one-cycle pulse that squashes IF/ID.
REQ-016 Port: stall_ex  out  1  holds the EX stage.
REQ-017 Port: misalign_exc  out  1  one-cycle pulse: the target is not 4-byte aligned.
REQ-018 Port: br_cnt  out  CNT_W  count of resolved control-transfer instructions.
REQ-019 Port: taken_cnt  out  CNT_W  count of taken control transfers.

Function
REQ-020 Fetch is static predict-not-taken, so taken = ex_valid AND (BR_JAL, OR BR_JALR, OR (BR_COND AND cmp_res)).
REQ-021 Target SHALL be ex_pc+ex_imm for BR_COND and BR_JAL, and (ex_rs1+ex_imm) with bit 0 cleared for BR_JALR; addition is 64-bit modulo 2^64.
REQ-022 The state machine SHALL have two states: IDLE and REDIR.
REQ-023 IDLE -> REDIR occurs when taken=1, target[1:0]==0 and trap_flush=0; the target is registered into redirect_pc on that edge.
REQ-024 Latency: redirect_valid and flush_front SHALL assert in the cycle after the taken instruction is presented.
REQ-025 flush_front SHALL be high only in the first cycle of REDIR.
REQ-026 In REDIR, redirect_valid=1 and redirect_pc SHALL stay stable until the cycle in which redirect_valid AND redirect_ready are both high.
REQ-027 The FSM SHALL return to IDLE on the edge that ends the handshake cycle.
REQ-028 stall_ex SHALL equal 1 whenever the state is REDIR.
REQ-029 In REDIR, the ex_* inputs and cmp_res SHALL be ignored, and the counters SHALL not update.
REQ-030 A handshake in the first REDIR cycle SHALL be legal, giving a minimum REDIR duration of 1 cycle.
REQ-031 Misaligned case: when taken=1 and target[1:0]!=0, misalign_exc SHALL pulse in the next cycle, the state SHALL stay IDLE, no redirect SHALL be issued, and br_cnt SHALL still increment.
REQ-032 trap_flush=1 in IDLE SHALL suppress any transition and any counter update.
REQ-033 trap_flush=1 in REDIR SHALL force the state to IDLE on the next edge and drop redirect_valid, even if redirect_ready=1 in the same cycle.
REQ-034 br_cnt SHALL increment by 1 per IDLE cycle in which ex_valid=1, ex_br_type!=BR_NONE and trap_flush=0.
REQ-035 taken_cnt SHALL increment on each IDLE->REDIR transition only.
REQ-036 Both counters SHALL wrap modulo 2^CNT_W without saturation.
REQ-037 ex_valid=0 SHALL produce no action regardless of ex_br_type.

Reset
REQ-038 While rstn=0, all registered state SHALL clear asynchronously: state=IDLE, redirect_valid=0, redirect_pc=0, flush_front=0, stall_ex=0, misalign_exc=0, br_cnt=0, taken_cnt=0.
REQ-039 A reset asserted in REDIR SHALL abort the redirect immediately, with no handshake completing.
REQ-040 After rstn rises, the first evaluated edge SHALL operate from IDLE.

Structure
REQ-041 br_type_enum, the FSM state enum, and addr_t/data_t SHALL reside in CorePack.
REQ-042 Target computation SHALL be a combinational sub-module named br_target, whose inputs are type, pc, imm and rs1 and whose outputs are target and misaligned.
REQ-043 The statistics counters SHALL be in-line registers with no further sub-modules.

Verification
REQ-044 BR_COND, ex_pc=0x1000, ex_imm=0x40, cmp_res=1, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x1040, flush_front=1, stall_ex=1; IDLE after; taken_cnt=1.
REQ-045 BR_JALR, ex_rs1=0x2003, ex_imm=0x1 (target 0x2004), redirect_ready held 0 for 3 cycles -> redirect_valid and redirect_pc=0x2004 stay stable for 4 cycles; flush_front high only in the first of them.
REQ-046 BR_JAL, ex_pc=0x1000, ex_imm=0x6 -> misalign_exc pulse, no redirect_valid, br_cnt=1, taken_cnt=0.
REQ-047 In REDIR, trap_flush=1 together with redirect_ready=1 -> next cycle redirect_valid=0, state IDLE, counters unchanged.
REQ-048 BR_COND with cmp_res=0 repeated 2^CNT_W+1 times (CNT_W=4: 17 times) -> br_cnt=1, taken_cnt=0, no redirect.
REQ-049 rstn pulsed low mid-REDIR -> all outputs 0 during reset; no redirect after release.
